// File: rtl/dual_input_debouncer.sv
// Two independent glitch filters for raw PS/2 clock/data pins: each input is
// double-flop synchronised and only forwarded once it has held a new level.
module dual_input_debouncer #(
    parameter int unsigned STABLE_CYCLES = 19,
    parameter logic        IDLE_LEVEL    = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic In0,
    input  logic In1,
    output logic Out0,
    output logic Out1
);

    localparam int unsigned CW = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(STABLE_CYCLES - 1);

    logic [1:0] raw_in;
    logic [1:0] out_vec;

    assign raw_in = {In1, In0};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ch
            logic          s1_q;
            logic          s2_q;
            logic          out_q;
            logic          out_d;
            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;

            // Count consecutive disagreeing samples; any agreement or a completed
            // count restarts from zero, so the counter can never wrap.
            always_comb begin
                out_d = out_q;
                cnt_d = '0;
                if (s2_q != out_q) begin
                    if (cnt_q == LAST_COUNT) begin
                        out_d = s2_q;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1_q  <= IDLE_LEVEL;
                    s2_q  <= IDLE_LEVEL;
                    out_q <= IDLE_LEVEL;
                    cnt_q <= '0;
                end else begin
                    s1_q  <= raw_in[gi];
                    s2_q  <= s1_q;
                    out_q <= out_d;
                    cnt_q <= cnt_d;
                end
            end

            assign out_vec[gi] = out_q;
        end
    endgenerate

    assign Out0 = out_vec[0];
    assign Out1 = out_vec[1];

endmodule

// File: tb/tb_dual_input_debouncer.sv
// Bench for dual_input_debouncer: directed latency/glitch scenarios plus random
// runs against a sliding-window reference model (one instance at 19, one at 1).
module tb_dual_input_debouncer;

    localparam int N_A = 19;
    localparam int N_B = 1;
    localparam int WIN [4] = '{N_A, N_A, N_B, N_B};

    logic clk = 1'b0;
    logic rst;
    logic In0, In1;
    logic Out0, Out1;
    logic Out0_b, Out1_b;

    int total = 0;
    int bad   = 0;

    // Reference model state: input samples and s2-level samples since reset.
    bit hist [4][$];
    bit s2h  [4][$];
    bit exp_o[4];

    always #5 clk = ~clk;

    dual_input_debouncer #(.STABLE_CYCLES(N_A), .IDLE_LEVEL(1'b1)) dut (
        .clk(clk), .rst(rst), .In0(In0), .In1(In1), .Out0(Out0), .Out1(Out1)
    );

    dual_input_debouncer #(.STABLE_CYCLES(N_B), .IDLE_LEVEL(1'b1)) dut_b (
        .clk(clk), .rst(rst), .In0(In0), .In1(In1), .Out0(Out0_b), .Out1(Out1_b)
    );

    task automatic model_reset();
        for (int ch = 0; ch < 4; ch++) begin
            hist[ch].delete();
            hist[ch].push_back(1'b1);
            hist[ch].push_back(1'b1);
            s2h[ch].delete();
            exp_o[ch] = 1'b1;
        end
    endtask

    // Output flips to the synchronised level once the last WIN synchronised
    // samples (since reset) all differ from the current output.
    task automatic model_edge();
        bit in_now[4];
        in_now = '{In0, In1, In0, In1};
        for (int ch = 0; ch < 4; ch++) begin
            int n;
            int m;
            bit s2;
            bit all_diff;
            n = hist[ch].size();
            s2 = hist[ch][n-2];
            s2h[ch].push_back(s2);
            hist[ch].push_back(in_now[ch]);
            m = s2h[ch].size();
            if (m >= WIN[ch]) begin
                all_diff = 1'b1;
                for (int k = m - WIN[ch]; k < m; k++)
                    if (s2h[ch][k] == exp_o[ch]) all_diff = 1'b0;
                if (all_diff) exp_o[ch] = s2;
            end
        end
    endtask

    task automatic step(input bit a, input bit b);
        @(negedge clk);
        In0 = a;
        In1 = b;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        bit stayed;
        rst = 1'b1; In0 = 1'b1; In1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (Out0 !== 1'b1) begin bad++; $display("FAIL reset_out0: got %b expected 1", Out0); end
        total++; if (Out1 !== 1'b1) begin bad++; $display("FAIL reset_out1: got %b expected 1", Out1); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (25) step(1'b0, 1'b0);
        total++; if ({Out0, Out1} !== 2'b00) begin bad++; $display("FAIL pre_reset_low: got %b%b expected 00", Out0, Out1); end
        // Assert reset between edges: outputs must go high without a clock edge.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++; if ({Out0, Out1} !== 2'b11) begin bad++; $display("FAIL async_reset: got %b%b expected 11", Out0, Out1); end
        total++; if ({Out0_b, Out1_b} !== 2'b11) begin bad++; $display("FAIL async_reset_b: got %b%b expected 11", Out0_b, Out1_b); end
        In0 = 1'b1; In1 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        stayed = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step(1'b1, 1'b1);
            if ({Out0, Out1} !== 2'b11) stayed = 1'b0;
        end
        total++; if (stayed !== 1'b1) begin bad++; $display("FAIL post_reset_idle: got %b expected 1", stayed); end
    endtask

    task automatic test_clean_edge();
        int fell;
        bit out1_moved;
        repeat (25) step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        fell = -1;
        out1_moved = 1'b0;
        for (int k = 1; k <= 60 && fell < 0; k++) begin
            step(1'b0, 1'b1);
            if (Out0 === 1'b0) fell = k;
            if (Out1 !== 1'b1) out1_moved = 1'b1;
        end
        total++; if (fell != 20) begin bad++; $display("FAIL clean_edge_latency: got %0d expected 20", fell); end
        total++; if (out1_moved !== 1'b0) begin bad++; $display("FAIL clean_edge_out1: got %b expected 0", out1_moved); end
        repeat (25) step(1'b1, 1'b1);
        total++; if (Out0 !== 1'b1) begin bad++; $display("FAIL clean_edge_restore: got %b expected 1", Out0); end
    endtask

    task automatic test_glitch();
        bit dropped;
        int fell;
        int rose;
        repeat (25) step(1'b1, 1'b1);
        dropped = 1'b0;
        repeat (10) begin step(1'b1, 1'b0); if (Out1 !== 1'b1) dropped = 1'b1; end
        repeat (30) begin step(1'b1, 1'b1); if (Out1 !== 1'b1) dropped = 1'b1; end
        total++; if (dropped !== 1'b0) begin bad++; $display("FAIL glitch_10_rejected: got %b expected 0", dropped); end
        step(1'b1, 1'b0);
        fell = -1;
        for (int k = 1; k < 25; k++) begin
            step(1'b1, 1'b0);
            if (fell < 0 && Out1 === 1'b0) fell = k;
        end
        total++; if (fell != 20) begin bad++; $display("FAIL glitch_25_fall: got %0d expected 20", fell); end
        step(1'b1, 1'b1);
        rose = -1;
        for (int k = 1; k <= 60 && rose < 0; k++) begin
            step(1'b1, 1'b1);
            if (Out1 === 1'b1) rose = k;
        end
        total++; if (rose != 20) begin bad++; $display("FAIL glitch_25_rise: got %0d expected 20", rose); end
    endtask

    task automatic test_bounce();
        bit dropped;
        int fell;
        repeat (25) step(1'b1, 1'b1);
        dropped = 1'b0;
        for (int p = 0; p < 40; p++) begin
            repeat (5) begin
                step((p % 2) == 1, 1'b1);
                if (Out0 !== 1'b1) dropped = 1'b1;
            end
        end
        total++; if (dropped !== 1'b0) begin bad++; $display("FAIL bounce_held: got %b expected 0", dropped); end
        step(1'b0, 1'b1);
        fell = -1;
        for (int k = 1; k <= 60 && fell < 0; k++) begin
            step(1'b0, 1'b1);
            if (Out0 === 1'b0) fell = k;
        end
        total++; if (fell != 20) begin bad++; $display("FAIL bounce_settle: got %0d expected 20", fell); end
        repeat (25) step(1'b1, 1'b1);
    endtask

    task automatic test_simultaneous();
        int f0, f1, r0, r1;
        repeat (25) step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        f0 = -1; f1 = -1;
        for (int k = 1; k <= 60; k++) begin
            step(1'b0, 1'b0);
            if (f0 < 0 && Out0 === 1'b0) f0 = k;
            if (f1 < 0 && Out1 === 1'b0) f1 = k;
        end
        total++; if (f0 != 20) begin bad++; $display("FAIL simul_fall0: got %0d expected 20", f0); end
        total++; if (f1 != 20) begin bad++; $display("FAIL simul_fall1: got %0d expected 20", f1); end
        step(1'b1, 1'b1);
        r0 = -1; r1 = -1;
        for (int k = 1; k <= 60; k++) begin
            step(1'b1, 1'b1);
            if (r0 < 0 && Out0 === 1'b1) r0 = k;
            if (r1 < 0 && Out1 === 1'b1) r1 = k;
        end
        total++; if (r0 != 20 || r1 != 20) begin bad++; $display("FAIL simul_rise: got %0d/%0d expected 20/20", r0, r1); end
    endtask

    task automatic test_param_corner();
        bit exp_seq[4];
        bit a_moved;
        exp_seq = '{1'b1, 1'b1, 1'b0, 1'b1};
        repeat (25) step(1'b1, 1'b1);
        a_moved = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(k == 0 ? 1'b0 : 1'b1, 1'b1);
            total++;
            if (Out0_b !== exp_seq[k]) begin
                bad++;
                $display("FAIL corner_pulse_k%0d: got %b expected %b", k, Out0_b, exp_seq[k]);
            end
            if (Out0 !== 1'b1) a_moved = 1'b1;
        end
        total++; if (a_moved !== 1'b0) begin bad++; $display("FAIL corner_default_ignores: got %b expected 0", a_moved); end
    endtask

    task automatic test_random();
        bit lvl[2];
        int left[2];
        bit got[4];
        int errs;
        lvl = '{1'b1, 1'b1};
        left = '{0, 0};
        errs = 0;
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < 2; c++) begin
                if (left[c] == 0) begin
                    lvl[c] = $urandom_range(0, 1) == 1;
                    left[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(10, 40);
                end
                left[c]--;
            end
            step(lvl[0], lvl[1]);
            got = '{Out0, Out1, Out0_b, Out1_b};
            for (int ch = 0; ch < 4; ch++) begin
                total++;
                if (got[ch] !== exp_o[ch]) begin
                    bad++;
                    if (errs < 20) $display("FAIL random_ch%0d_cyc%0d: got %b expected %b", ch, i, got[ch], exp_o[ch]);
                    errs++;
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clean_edge();
        test_glitch();
        test_bounce();
        test_simultaneous();
        test_param_corner();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dual_input_debouncer.md
Name: dual_input_debouncer

Overview:
- Two-channel glitch filter between the raw PS/2 pins (keyboard clock and keyboard data) and the PS/2 receiver's negedge-sampled frame logic.
- Each channel synchronises its asynchronous input into the onboard clock domain.
- Each output changes only after the synchronised input has held a new level for a programmable number of consecutive clocks.
- Channels are fully independent; the onboard clock is 25 MHz.

Parameters:
- STABLE_CYCLES, 19, consecutive clk cycles a changed level must persist before the output follows (about 0.76 us at 25 MHz, well below PS/2 half-period). Legal range is 1 to 65535.
- IDLE_LEVEL, 1'b1, reset value of synchronisers and outputs (PS/2 lines idle high).

Ports:
- clk  input  1  onboard system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- In0  input  1  raw channel 0 (keyboard clock), asynchronous to clk.
- In1  input  1  raw channel 1 (keyboard data), asynchronous to clk.
- Out0  output  1  debounced channel 0, registered.
- Out1  output  1  debounced channel 1, registered.

Behaviour:
- Reset (rst=1, asynchronous, any time, including mid-count):
  - both synchroniser stages of each channel = IDLE_LEVEL;
  - Out0 = Out1 = IDLE_LEVEL;
  - both counters = 0.
  - Outputs stay at IDLE_LEVEL while rst is held.
  - Normal operation resumes on the first rising clk edge after rst deasserts.
- Per-channel datapath, identical for channel 0 and channel 1:
  - 2-flop synchroniser: s1 <= In; s2 <= s1.
  - Counter cnt, width ceil(log2(STABLE_CYCLES))+1, never wraps.
- Per-channel rules, evaluated each rising edge:
  - s2 == Out: cnt <= 0; Out holds.
  - s2 != Out and cnt < STABLE_CYCLES-1: cnt <= cnt+1; Out holds.
  - s2 != Out and cnt == STABLE_CYCLES-1: Out <= s2; cnt <= 0.
- Latency: if a new level is first captured into s1 at edge E0 and stays stable, Out changes at edge E0+STABLE_CYCLES+1.
  - For the default of 19, that is 20 edges after capture.
- Glitch rejection:
  - any return of s2 to the current Out level before the count completes clears cnt to 0;
  - a pulse lasting fewer than STABLE_CYCLES cycles at s2 never reaches Out;
  - a pulse lasting exactly STABLE_CYCLES cycles at s2 does propagate.
- STABLE_CYCLES = 1: Out follows s2 one edge later (pure 3-flop delay).
- Channels do not interact. Simultaneous changes on In0 and In1 are filtered independently with identical latency.
- Out is glitch-free: at most one transition per qualifying input change, and no combinational path from In to Out.
- No other outputs, no enables; the counter saturates by construction.

Test Plan:
- Reset check: assert rst mid-operation with Out0=0 and Out1=0 → both outputs go to 1 immediately, without waiting for clk. After release with In0=In1=1 → outputs stay 1 indefinitely.
- Clean edge (default parameters): hold In0 high, drive In0 low just before edge E0 and hold it → Out0 falls exactly at E0+20; Out1 is unchanged.
- Glitch rejection: from idle high, pulse In1 low for 10 clk cycles, then high → Out1 stays 1 and the counter returns to 0. Then pulse low for 25 cycles → Out1 falls after 20 edges and rises again 20 edges after In1 returns high.
- Bouncing input: toggle In0 every 5 cycles for 200 cycles, then hold it at 0 → Out0 stays 1 during bouncing and goes 0 exactly 20 edges after the final stable capture.
- Simultaneous channels: change In0 1→0 and In1 1→0 on the same edge → Out0 and Out1 fall on the same edge, 20 edges later.
- Parameter corner: STABLE_CYCLES=1 → Out tracks In with a 2-edge delay from s1 capture; a single-cycle low pulse appears as a single-cycle low pulse on Out.
